// File: rtl/capture_fft_sequencer.sv
// capture_fft_sequencer: triggered ADC frame capture into RAM, then Avalon-ST streaming into an FFT core.
// Optional macro SEQ_AUTO_REARM_EN: DONE returns to ARMED automatically instead of waiting for enable=0.
`default_nettype none

module capture_fft_sequencer #(
    parameter int DEPTH_LOG2 = 13,
    parameter int DATA_W     = 14
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  trig_in,
    input  logic                  smp_clk_in,
    input  logic [DATA_W-1:0]     adc_data,
    output logic                  ram_wren,
    output logic [DEPTH_LOG2-1:0] ram_wraddr,
    output logic [DATA_W-1:0]     ram_wrdata,
    output logic [DEPTH_LOG2-1:0] ram_rdaddr,
    input  logic [DATA_W-1:0]     ram_rddata,
    output logic                  fft_sink_valid,
    output logic                  fft_sink_sop,
    output logic                  fft_sink_eop,
    output logic [DATA_W-1:0]     fft_sink_data,
    input  logic                  fft_sink_ready,
    input  logic                  fft_source_valid,
    input  logic                  fft_source_sop,
    input  logic                  fft_source_eop,
    output logic                  fft_source_ready,
    output logic                  busy,
    output logic                  done,
    output logic [2:0]            state_o,
    output logic [15:0]           frame_cnt
);

    localparam logic [DEPTH_LOG2:0] LAST_IDX = (DEPTH_LOG2+1)'((1 << DEPTH_LOG2) - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ARMED    = 3'd1,
        CAPTURE  = 3'd2,
        WAIT_RDY = 3'd3,
        STREAM   = 3'd4,
        DRAIN    = 3'd5,
        DONE     = 3'd6
    } state_t;

    state_t                state;
    logic [2:0]            trig_sync;
    logic [2:0]            smp_sync;
    logic                  trig_rise;
    logic                  smp_rise;
    logic [DEPTH_LOG2-1:0] wr_cnt;
    logic [DEPTH_LOG2:0]   rd_cnt;
    logic [DEPTH_LOG2:0]   load_cnt;
    logic                  pend;
    logic                  skid_valid;
    logic [DATA_W-1:0]     skid_data;
    logic                  xfer;
    logic                  out_free;
    logic [1:0]            held;
    logic                  can_issue;
    logic                  unused_src_sop;

    // Bits 0/1 are the synchroniser pair; bit 2 is history for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            trig_sync <= '0;
            smp_sync  <= '0;
        end else begin
            trig_sync <= {trig_sync[1:0], trig_in};
            smp_sync  <= {smp_sync[1:0], smp_clk_in};
        end
    end

    assign trig_rise = trig_sync[1] & ~trig_sync[2];
    assign smp_rise  = smp_sync[1] & ~smp_sync[2];

    assign xfer     = fft_sink_valid & fft_sink_ready;
    assign out_free = ~fft_sink_valid | fft_sink_ready;
    // Samples still owned by the pipeline after this edge; output + skid hold at most two.
    assign held      = {1'b0, fft_sink_valid & ~fft_sink_ready} + {1'b0, skid_valid} + {1'b0, pend};
    assign can_issue = ~held[1] & ~rd_cnt[DEPTH_LOG2];

    assign state_o        = state;
    assign unused_src_sop = fft_source_sop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            ram_wren         <= 1'b0;
            ram_wraddr       <= '0;
            ram_wrdata       <= '0;
            ram_rdaddr       <= '0;
            fft_sink_valid   <= 1'b0;
            fft_sink_sop     <= 1'b0;
            fft_sink_eop     <= 1'b0;
            fft_sink_data    <= '0;
            fft_source_ready <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            frame_cnt        <= '0;
            wr_cnt           <= '0;
            rd_cnt           <= '0;
            load_cnt         <= '0;
            pend             <= 1'b0;
            skid_valid       <= 1'b0;
            skid_data        <= '0;
        end else begin
            ram_wren <= 1'b0;
            done     <= 1'b0;
            if (!enable) begin
                state            <= IDLE;
                busy             <= 1'b0;
                fft_source_ready <= 1'b0;
                fft_sink_valid   <= 1'b0;
                fft_sink_sop     <= 1'b0;
                fft_sink_eop     <= 1'b0;
                wr_cnt           <= '0;
                rd_cnt           <= '0;
                load_cnt         <= '0;
                pend             <= 1'b0;
                skid_valid       <= 1'b0;
                ram_rdaddr       <= '0;
                ram_wraddr       <= '0;
            end else begin
                case (state)
                    IDLE: state <= ARMED;
                    ARMED: begin
                        if (trig_rise) begin
                            state  <= CAPTURE;
                            busy   <= 1'b1;
                            wr_cnt <= '0;
                        end
                    end
                    CAPTURE: begin
                        if (smp_rise) begin
                            ram_wren   <= 1'b1;
                            ram_wrdata <= adc_data;
                            ram_wraddr <= wr_cnt;
                            wr_cnt     <= wr_cnt + 1'b1;
                            if (&wr_cnt) state <= WAIT_RDY;
                        end
                    end
                    WAIT_RDY: begin
                        // Address 0 is already on ram_rdaddr, so this edge is the prefetch read.
                        if (fft_sink_ready) begin
                            state      <= STREAM;
                            pend       <= 1'b1;
                            rd_cnt     <= (DEPTH_LOG2+1)'(1);
                            ram_rdaddr <= DEPTH_LOG2'(1);
                        end
                    end
                    STREAM: begin
                        if (out_free) begin
                            if (skid_valid) begin
                                fft_sink_valid <= 1'b1;
                                fft_sink_data  <= skid_data;
                                fft_sink_sop   <= (load_cnt == '0);
                                fft_sink_eop   <= (load_cnt == LAST_IDX);
                                load_cnt       <= load_cnt + 1'b1;
                                skid_valid     <= pend;
                                skid_data      <= ram_rddata;
                            end else if (pend) begin
                                fft_sink_valid <= 1'b1;
                                fft_sink_data  <= ram_rddata;
                                fft_sink_sop   <= (load_cnt == '0);
                                fft_sink_eop   <= (load_cnt == LAST_IDX);
                                load_cnt       <= load_cnt + 1'b1;
                            end else begin
                                fft_sink_valid <= 1'b0;
                                fft_sink_sop   <= 1'b0;
                                fft_sink_eop   <= 1'b0;
                            end
                        end else if (pend) begin
                            skid_valid <= 1'b1;
                            skid_data  <= ram_rddata;
                        end
                        if (can_issue) begin
                            pend       <= 1'b1;
                            rd_cnt     <= rd_cnt + 1'b1;
                            ram_rdaddr <= ram_rdaddr + 1'b1;
                        end else begin
                            pend <= 1'b0;
                        end
                        if (xfer && fft_sink_eop) begin
                            state            <= DRAIN;
                            fft_source_ready <= 1'b1;
                            fft_sink_valid   <= 1'b0;
                            fft_sink_sop     <= 1'b0;
                            fft_sink_eop     <= 1'b0;
                            rd_cnt           <= '0;
                            load_cnt         <= '0;
                            pend             <= 1'b0;
                            skid_valid       <= 1'b0;
                            ram_rdaddr       <= '0;
                        end
                    end
                    DRAIN: begin
                        if (fft_source_valid && fft_source_eop) begin
                            state            <= DONE;
                            fft_source_ready <= 1'b0;
                            done             <= 1'b1;
                            frame_cnt        <= frame_cnt + 1'b1;
                        end
                    end
                    DONE: begin
`ifdef SEQ_AUTO_REARM_EN
                        state <= ARMED;
                        busy  <= 1'b0;
`else
                        state <= DONE;
`endif
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_capture_fft_sequencer.sv
// Randomised scoreboard bench for capture_fft_sequencer (N=16) with a behavioural RAM and frame model.
`default_nettype none

module tb_capture_fft_sequencer;

    localparam int DL = 4;
    localparam int DW = 14;
    localparam int N  = 16;

    logic          clk = 1'b0;
    logic          reset, enable, trig_in, smp_clk_in;
    logic [DW-1:0] adc_data;
    logic          ram_wren;
    logic [DL-1:0] ram_wraddr, ram_rdaddr;
    logic [DW-1:0] ram_wrdata, ram_rddata;
    logic          fft_sink_valid, fft_sink_sop, fft_sink_eop, fft_sink_ready;
    logic [DW-1:0] fft_sink_data;
    logic          fft_source_valid, fft_source_sop, fft_source_eop, fft_source_ready;
    logic          busy, done;
    logic [2:0]    state_o;
    logic [15:0]   frame_cnt;

    capture_fft_sequencer #(.DEPTH_LOG2(DL), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset), .enable(enable), .trig_in(trig_in), .smp_clk_in(smp_clk_in),
        .adc_data(adc_data), .ram_wren(ram_wren), .ram_wraddr(ram_wraddr), .ram_wrdata(ram_wrdata),
        .ram_rdaddr(ram_rdaddr), .ram_rddata(ram_rddata),
        .fft_sink_valid(fft_sink_valid), .fft_sink_sop(fft_sink_sop), .fft_sink_eop(fft_sink_eop),
        .fft_sink_data(fft_sink_data), .fft_sink_ready(fft_sink_ready),
        .fft_source_valid(fft_source_valid), .fft_source_sop(fft_source_sop),
        .fft_source_eop(fft_source_eop), .fft_source_ready(fft_source_ready),
        .busy(busy), .done(done), .state_o(state_o), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    // Two-port RAM with one clock of read latency.
    logic [DW-1:0] mem [N];
    always @(posedge clk) begin
        if (ram_wren) mem[ram_wraddr] <= ram_wrdata;
        ram_rddata <= mem[ram_rdaddr];
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int beats, first_cyc, last_cyc;
    logic [DL+DW-1:0] wrq[$];
    logic [DW+1:0]    sinkq[$];
    logic [DW-1:0]    model[N];
    logic [15:0]      fc_model = 16'd0;
    bit               ready_en = 1'b0;
    int               ready_mode = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string name);
        int k = 0;
        while (state_o !== s && k < budget) begin @(negedge clk); k++; end
        check(name, state_o, s);
    endtask

    task automatic pulse_trig();
        trig_in = 1'b1; tick(3); trig_in = 1'b0; tick(3);
    endtask

    task automatic strobe(input logic [DW-1:0] d);
        adc_data = d; tick(2); smp_clk_in = 1'b1; tick(3); smp_clk_in = 1'b0; tick(3);
    endtask

    initial forever begin @(posedge clk); cyc++; end

    initial begin : ready_driver
        int rcnt = 0;
        logic [3:0] pat = 4'b1001;
        fft_sink_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (!ready_en) begin
                fft_sink_ready = 1'b0; rcnt = 0;
            end else begin
                case (ready_mode)
                    0:       fft_sink_ready = 1'b1;
                    1:       fft_sink_ready = pat[rcnt % 4];
                    default: fft_sink_ready = 1'($urandom_range(0, 1));
                endcase
                rcnt++;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT writes RAM or completes a sink transfer.
    initial begin : monitor
        bit            stall_prev = 1'b0;
        logic [DW+1:0] stall_beat = '0;
        logic [DW+1:0] cur, e;
        logic [DL+DW-1:0] w;
        forever begin
            @(negedge clk);
            cur = {fft_sink_data, fft_sink_sop, fft_sink_eop};
            if (ram_wren) begin
                if (wrq.size() == 0) check("unexpected_ram_write", 32'(ram_wraddr), 32'hFFFF);
                else begin
                    w = wrq.pop_front();
                    check("wr_addr", 32'(ram_wraddr), 32'(w[DL+DW-1:DW]));
                    check("wr_data", 32'(ram_wrdata), 32'(w[DW-1:0]));
                end
            end
            if (fft_sink_valid && state_o != 3'd4) check("valid_outside_stream", 32'(state_o), 32'd4);
            if (stall_prev) begin
                check("stall_valid_held", 32'(fft_sink_valid), 32'd1);
                check("stall_beat_held", 32'(cur), 32'(stall_beat));
            end
            if (fft_sink_valid && fft_sink_ready) begin
                if (sinkq.size() == 0) check("unexpected_beat", 32'(cur), 32'hFFFFF);
                else begin
                    e = sinkq.pop_front();
                    check("sink_beat", 32'(cur), 32'(e));
                end
                beats++;
                if (beats == 1) first_cyc = cyc;
                last_cyc = cyc;
            end
            stall_prev = fft_sink_valid && !fft_sink_ready;
            stall_beat = cur;
        end
    end

    task automatic run_frame(input int dmode, input int rmode, input bit trig_mid);
        logic [DW-1:0] d;
        wait_state(3'd1, 20, "armed_before_frame");
        pulse_trig();
        wait_state(3'd2, 10, "capture_entered");
        for (int i = 0; i < N; i++) begin
            d = (dmode == 0) ? DW'(32'h100 + i) : DW'($urandom);
            model[i] = d;
            wrq.push_back({DL'(i), d});
            strobe(d);
        end
        tick(2);
        @(negedge clk);
        check("state_wait_rdy", 32'(state_o), 32'd3);
        check("writes_all_seen", 32'(wrq.size()), 32'd0);
        for (int i = 0; i < N; i++) check("ram_content", 32'(mem[i]), 32'(model[i]));
        for (int i = 0; i < N; i++) sinkq.push_back({model[i], i == 0, i == N - 1});
        beats = 0;
        ready_mode = rmode;
        @(posedge clk); #1;
        ready_en = 1'b1;
        if (trig_mid) begin
            wait_state(3'd4, 20, "stream_entered");
            pulse_trig();
        end
        wait_state(3'd5, 600, "drain_reached");
        ready_en = 1'b0;
        check("beat_count", 32'(beats), 32'd16);
        check("beats_all_seen", 32'(sinkq.size()), 32'd0);
        check("source_ready_in_drain", 32'(fft_source_ready), 32'd1);
        check("sink_valid_in_drain", 32'(fft_sink_valid), 32'd0);
        if (rmode == 0) check("consecutive_beats", 32'(last_cyc - first_cyc), 32'd15);
        @(posedge clk); #1;
        fft_source_valid = 1'b1; fft_source_eop = 1'b1; fft_source_sop = 1'b1;
        @(posedge clk); #1;
        fft_source_valid = 1'b0; fft_source_eop = 1'b0; fft_source_sop = 1'b0;
        @(negedge clk);
        fc_model = fc_model + 16'd1;
        check("done_pulse", 32'(done), 32'd1);
        check("frame_cnt", 32'(frame_cnt), 32'(fc_model));
        check("state_done", 32'(state_o), 32'd6);
        check("source_ready_after_done", 32'(fft_source_ready), 32'd0);
        @(negedge clk);
        check("done_one_clock", 32'(done), 32'd0);
`ifdef SEQ_AUTO_REARM_EN
        check("auto_rearm_state", 32'(state_o), 32'd1);
`else
        check("done_holds_state", 32'(state_o), 32'd6);
        tick(3);
        @(negedge clk);
        check("done_still_holds", 32'(state_o), 32'd6);
        enable = 1'b0; tick(1);
        @(negedge clk);
        check("done_to_idle", 32'(state_o), 32'd0);
        enable = 1'b1;
`endif
    endtask

    task automatic abort_frame(input bit use_reset);
        logic [DW-1:0] d;
        wait_state(3'd1, 20, "armed_before_abort");
        pulse_trig();
        wait_state(3'd2, 10, "capture_before_abort");
        for (int i = 0; i < 7; i++) begin
            d = DW'($urandom);
            wrq.push_back({DL'(i), d});
            strobe(d);
        end
        tick(1);
        if (use_reset) begin
            reset = 1'b1; tick(2); reset = 1'b0;
            fc_model = 16'd0;
        end else begin
            enable = 1'b0; tick(1);
        end
        @(negedge clk);
        check("abort_state_idle", 32'(state_o), 32'd0);
        check("abort_wren_low", 32'(ram_wren), 32'd0);
        check("abort_busy_low", 32'(busy), 32'd0);
        check("abort_writes_seen", 32'(wrq.size()), 32'd7 - 32'd7);
        if (use_reset) check("abort_frame_cnt", 32'(frame_cnt), 32'd0);
        enable = 1'b1;
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        reset = 1'b1; enable = 1'b0; trig_in = 1'b0; smp_clk_in = 1'b0; adc_data = '0;
        fft_source_valid = 1'b0; fft_source_sop = 1'b0; fft_source_eop = 1'b0;
        tick(3);
        reset = 1'b0;
        @(negedge clk);
        check("rst_state", 32'(state_o), 32'd0);
        check("rst_wren", 32'(ram_wren), 32'd0);
        check("rst_sink_valid", 32'(fft_sink_valid), 32'd0);
        check("rst_sop", 32'(fft_sink_sop), 32'd0);
        check("rst_eop", 32'(fft_sink_eop), 32'd0);
        check("rst_source_ready", 32'(fft_source_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("rst_wraddr", 32'(ram_wraddr), 32'd0);
        check("rst_rdaddr", 32'(ram_rdaddr), 32'd0);
        enable = 1'b1;
        run_frame(0, 0, 1'b0);
        run_frame(1, 1, 1'b0);
        abort_frame(1'b0);
        run_frame(1, 2, 1'b1);
        abort_frame(1'b1);
        run_frame(1, 0, 1'b0);
        tick(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/capture_fft_sequencer.md
CAPTURE_FFT_SEQUENCER -- requirements
Module: capture_fft_sequencer

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 13, meaning frame length N = 2^DEPTH_LOG2 samples (8192).
REQ-002 SHALL have parameter DATA_W, default 14, meaning ADC sample width.
REQ-003 SHALL have port clk  in  1  sole clock (65 MHz ADC domain); all logic on its rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port enable  in  1  level; 0 forces return to IDLE at the next clock edge.
REQ-006 SHALL have port trig_in  in  1  external trigger (SMA), asynchronous.
REQ-007 SHALL have port smp_clk_in  in  1  external sample strobe, asynchronous.
REQ-008 SHALL have port adc_data  in  DATA_W  ADC sample.
REQ-009 SHALL have ports ram_wren/ram_wraddr/ram_wrdata  out  1/DEPTH_LOG2/DATA_W  two-port RAM write side.
REQ-010 SHALL have ports ram_rdaddr  out  DEPTH_LOG2 and ram_rddata  in  DATA_W; RAM read latency is exactly 1 clock.
REQ-011 SHALL have ports fft_sink_valid/sop/eop  out  1 each, fft_sink_data  out  DATA_W, fft_sink_ready  in  1 (Avalon-ST, readyLatency 0).
REQ-012 SHALL have ports fft_source_valid/sop/eop  in  1 each and fft_source_ready  out  1.
REQ-013 SHALL have ports busy  out  1, done  out  1 (one-clock pulse), state_o  out  3, frame_cnt  out  16.

Function
REQ-014 SHALL synchronise trig_in and smp_clk_in through two flops each and detect rising edges on the synchronised signals.
REQ-015 SHALL implement states IDLE(0), ARMED(1), CAPTURE(2), WAIT_RDY(3), STREAM(4), DRAIN(5), DONE(6), driven on state_o.
REQ-016 SHALL move IDLE->ARMED when enable=1; ARMED->CAPTURE on a trig_in rising edge; rising edges in all other states are ignored.
REQ-017 SHALL in CAPTURE, on each smp_clk_in rising edge, assert ram_wren for exactly one clock with ram_wrdata=adc_data (sampled on the edge-detect cycle) and ram_wraddr=write count, then increment the count.
REQ-018 SHALL leave CAPTURE for WAIT_RDY on the same clock as the Nth write; write count wraps to 0.
REQ-019 SHALL move WAIT_RDY->STREAM on the first clock with fft_sink_ready=1.
REQ-020 SHALL in STREAM present samples 0..N-1 in address order, with fft_sink_sop=1 only on sample 0 and fft_sink_eop=1 only on sample N-1.
REQ-021 SHALL count a transfer only when fft_sink_valid and fft_sink_ready are both 1; while valid=1 and ready=0, data/sop/eop/valid are held stable.
REQ-022 SHALL hide the 1-clock RAM latency with a skid register so that with ready held at 1 the N samples are delivered in N consecutive clocks after a one-clock prefetch.
REQ-023 SHALL move STREAM->DRAIN on the clock the eop transfer completes; fft_source_ready=1 only in DRAIN.
REQ-024 SHALL move DRAIN->DONE on a clock where fft_source_valid and fft_source_eop are both 1, pulse done for that clock, and increment frame_cnt (modulo 2^16).
REQ-025 SHALL assert busy in every state except IDLE and ARMED.
REQ-026 SHALL, if enable=0 in any state, go to IDLE next clock, deassert ram_wren and fft_sink_valid, and clear the read/write counts; any partial frame is discarded.
REQ-027 SHALL not assert ram_wren outside CAPTURE nor fft_sink_valid outside STREAM.

Reset
REQ-028 SHALL on reset set state=IDLE, clear counts and synchroniser flops, and drive ram_wren=0, fft_sink_valid/sop/eop=0, fft_source_ready=0, busy=0, done=0, frame_cnt=0, ram_wraddr=0, ram_rdaddr=0.
REQ-029 SHALL, if reset asserts mid-frame, abandon the frame immediately with no further RAM writes or sink transfers.

Configuration
REQ-030 SHALL support macro SEQ_AUTO_REARM_EN: when defined, DONE->ARMED on the next clock; when undefined, DONE stays until enable=0 (then IDLE).

Verification (DEPTH_LOG2=4, N=16)
REQ-031 SHALL test: enable=1, trig rise, 16 strobes with adc_data=0x100+i -> RAM addr i holds 0x100+i, state reaches WAIT_RDY after 16th write.
REQ-032 SHALL test: ready tied 1 -> 16 consecutive valid beats, data 0x100..0x10F, sop on beat 0, eop on beat 15.
REQ-033 SHALL test: ready toggled 1,0,0,1 repeatedly -> data held during stalls, exactly 16 transfers, no duplicate or missing samples.
REQ-034 SHALL test: source_valid+eop pulse in DRAIN -> done=1 for one clock, frame_cnt 0->1; with SEQ_AUTO_REARM_EN state_o=1 next clock, without it state_o stays 6.
REQ-035 SHALL test: reset or enable=0 after 7 captured samples -> state_o=0, ram_wren=0, and a new trigger restarts writing at address 0.
REQ-036 SHALL test: trig rise during STREAM -> ignored, stream completes normally.
